// File: rtl/dma_rr_dscrptr_arbiter_if.sv
// Handshake bundle between one priority level's descriptor-valid logic,
// its round-robin arbiter, and the fixed-priority arbiter.
interface dma_rr_dscrptr_arbiter_if #(
   parameter int NUM_OF_BDS       = 4,
   parameter int NUM_OF_BDS_WIDTH = 2
);
   logic [NUM_OF_BDS-1:0]       dscrptrReq;
   logic                        strReq;
   logic                        reqEn;
   logic                        flush;
   logic                        req;
   logic [NUM_OF_BDS_WIDTH-1:0] intDscrptrNum;
   logic                        strDscrptr;

   // master: the round-robin arbiter that owns the registered candidate
   modport master (
      input  dscrptrReq, strReq, reqEn, flush,
      output req, intDscrptrNum, strDscrptr
   );

   modport slave (
      output dscrptrReq, strReq, reqEn, flush,
      input  req, intDscrptrNum, strDscrptr
   );
endinterface

// File: rtl/dma_rr_dscrptr_arbiter.sv
// Round-robin arbiter for one DMA priority level: alternates the stream source with
// a rotating scan of internal descriptors and offers one registered candidate upstream.
module dma_rr_dscrptr_arbiter #(
   parameter int NUM_OF_BDS       = 4,
   parameter int NUM_OF_BDS_WIDTH = 2,
   parameter int STR_EN           = 1
) (
   input logic                       clock,
   input logic                       resetn,
   dma_rr_dscrptr_arbiter_if.master  arbIf
);
   localparam logic [0:0] SCAN  = 1'b0;
   localparam logic [0:0] OFFER = 1'b1;

   localparam logic [NUM_OF_BDS_WIDTH-1:0] LAST_IDX = NUM_OF_BDS_WIDTH'(NUM_OF_BDS - 1);
   localparam logic [NUM_OF_BDS_WIDTH-1:0] ONE_IDX  = NUM_OF_BDS_WIDTH'(1);

   logic [0:0]                  state;
   logic                        reqReg;
   logic [NUM_OF_BDS_WIDTH-1:0] intNumReg;
   logic                        strReg;
   logic [NUM_OF_BDS_WIDTH-1:0] ptr;
   logic                        lastStr;

   logic                        intFound;
   logic [NUM_OF_BDS_WIDTH-1:0] intSel;
   logic                        strCand;
   logic                        pickStr;
   logic                        withdrawn;

   // Rotating scan split in two passes (ptr..top, then 0..ptr-1) so the wrap
   // happens at NUM_OF_BDS even when it is not a power of two.
   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
      intFound = 1'b0;
      intSel   = '0;
      for (int j = 0; j < NUM_OF_BDS; j++) begin
         if (!intFound && arbIf.dscrptrReq[j] && (j >= int'(ptr))) begin
            intFound = 1'b1;
            intSel   = j[NUM_OF_BDS_WIDTH-1:0];
         end
      end
      for (int j = 0; j < NUM_OF_BDS; j++) begin
         if (!intFound && arbIf.dscrptrReq[j] && (j < int'(ptr))) begin
            intFound = 1'b1;
            intSel   = j[NUM_OF_BDS_WIDTH-1:0];
         end
      end
   end

   assign strCand   = (STR_EN != 0) && arbIf.strReq;
   assign pickStr   = strCand && (!intFound || !lastStr);
   assign withdrawn = strReg ? !strCand : !arbIf.dscrptrReq[intNumReg];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= SCAN;
         reqReg    <= 1'b0;
         intNumReg <= '0;
         strReg    <= 1'b0;
         ptr       <= '0;
         lastStr   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            SCAN: begin
               if (arbIf.flush) begin
                  intNumReg <= '0;
                  strReg    <= 1'b0;
                  ptr       <= '0;
                  lastStr   <= 1'b0;
               end else if (intFound || strCand) begin
                  reqReg    <= 1'b1;
                  strReg    <= pickStr;
                  intNumReg <= pickStr ? '0 : intSel;
                  state     <= OFFER;
               end
            end
            OFFER: begin
               if (arbIf.flush) begin
                  reqReg    <= 1'b0;
                  intNumReg <= '0;
                  strReg    <= 1'b0;
                  ptr       <= '0;
                  lastStr   <= 1'b0;
                  state     <= SCAN;
               end else if (arbIf.reqEn) begin
                  // Grant wins over a simultaneous withdraw: upstream already latched the candidate.
                  if (strReg) begin
                     lastStr <= 1'b1;
                  end else begin
                     ptr     <= (intNumReg == LAST_IDX) ? '0 : intNumReg + ONE_IDX;
                     lastStr <= 1'b0;
                  end
                  reqReg <= 1'b0;
                  state  <= SCAN;
               end else if (withdrawn) begin
                  reqReg <= 1'b0;
                  state  <= SCAN;
               end
            end
            default: begin
               reqReg <= 1'b0;
               state  <= SCAN;
            end
         endcase
      end
   end

   assign arbIf.req           = reqReg;
   assign arbIf.intDscrptrNum = intNumReg;
   assign arbIf.strDscrptr    = strReg;
endmodule
